// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB write-back select, 32x32 register file, forwarding record and commit counter
module wb_regfile #(
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       WB_i,
    input  logic [31:0]      ReadData_i,
    input  logic [31:0]      immed_i,
    input  logic [4:0]       mux3_i,
    input  logic [4:0]       RSaddr_i,
    input  logic [4:0]       RTaddr_i,
    output logic [31:0]      RSdata_o,
    output logic [31:0]      RTdata_o,
    output logic [31:0]      WBdata_o,
    output logic             fwd_valid_o,
    output logic [4:0]       fwd_rd_o,
    output logic [31:0]      fwd_data_o,
    output logic [CNT_W-1:0] commit_cnt_o
);

    logic [31:0] regs [NREG];
    logic        we;

    // Write-back value selection and write qualification; r0 writes are dropped entirely
    always_comb begin
        WBdata_o = WB_i[0] ? ReadData_i : immed_i;
        we       = WB_i[1] && (mux3_i != 5'd0);
    end

    // Read port A with same-cycle write-through so ID sees the value being committed
    always_comb begin
        RSdata_o = 32'd0;
        if (RSaddr_i != 5'd0) begin
            if (we && (RSaddr_i == mux3_i)) begin
                RSdata_o = WBdata_o;
            end else begin
                RSdata_o = regs[RSaddr_i];
            end
        end
    end

    // Read port B, identical to port A
    always_comb begin
        RTdata_o = 32'd0;
        if (RTaddr_i != 5'd0) begin
            if (we && (RTaddr_i == mux3_i)) begin
                RTdata_o = WBdata_o;
            end else begin
                RTdata_o = regs[RTaddr_i];
            end
        end
    end

    // Register array commit; r0 is never written so it stays zero after reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we) begin
            regs[mux3_i] <= WBdata_o;
        end
    end

    // Forwarding record of the last real commit; address/data hold across idle cycles
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_valid_o <= 1'b0;
            fwd_rd_o    <= 5'd0;
            fwd_data_o  <= 32'd0;
        end else begin
            fwd_valid_o <= we;
            if (we) begin
                fwd_rd_o   <= mux3_i;
                fwd_data_o <= WBdata_o;
            end
        end
    end

    // Commit counter, wrapping modulo 2^CNT_W
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            commit_cnt_o <= '0;
        end else if (we) begin
            commit_cnt_o <= commit_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized scoreboard bench for wb_regfile
module tb_wb_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [1:0]  WB_i = 2'b00;
    logic [31:0] ReadData_i = 32'd0;
    logic [31:0] immed_i = 32'd0;
    logic [4:0]  mux3_i = 5'd0;
    logic [4:0]  RSaddr_i = 5'd0;
    logic [4:0]  RTaddr_i = 5'd0;

    logic [31:0] RSdata_o, RTdata_o, WBdata_o, fwd_data_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [15:0] commit_cnt_o;

    logic [31:0] rs4, rt4, wb4, fd4;
    logic        fv4;
    logic [4:0]  fr4;
    logic [3:0]  cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    wb_regfile dut (
        .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .ReadData_i(ReadData_i),
        .immed_i(immed_i), .mux3_i(mux3_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .WBdata_o(WBdata_o),
        .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
        .commit_cnt_o(commit_cnt_o)
    );

    wb_regfile #(.NREG(32), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .ReadData_i(ReadData_i),
        .immed_i(immed_i), .mux3_i(mux3_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .RSdata_o(rs4), .RTdata_o(rt4), .WBdata_o(wb4),
        .fwd_valid_o(fv4), .fwd_rd_o(fr4), .fwd_data_o(fd4),
        .commit_cnt_o(cnt4)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mregs [32];
    int          mcount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit w,
                                               input logic [4:0] d, input logic [31:0] v);
        if (a == 0) return 32'd0;
        if (w && a == d) return v;
        return mregs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mcount = 0;
        exp_q.delete();
    endtask

    // One cycle of stimulus: inputs change on the falling edge, like the MEM/WB register
    task automatic drive(input logic [1:0] wb, input logic [31:0] rdata, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        logic [31:0] v;
        bit          w;
        exp_t        e;
        @(negedge clk_i);
        WB_i = wb; ReadData_i = rdata; immed_i = imm; mux3_i = rd;
        RSaddr_i = rs; RTaddr_i = rt;
        #1;
        v = wb[0] ? rdata : imm;
        w = wb[1] && (rd != 0);
        chk("wbdata", WBdata_o, v);
        chk("rs_read", RSdata_o, model_read(rs, w, rd, v));
        chk("rt_read", RTdata_o, model_read(rt, w, rd, v));
        chk("rs_read_cnt4", rs4, model_read(rs, w, rd, v));
        if (w) begin
            mregs[rd] = v;
            mcount++;
            e.rd = rd; e.data = v; e.cnt = mcount;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: after each rising edge compare the forwarding record and counters
    initial begin : monitor
        exp_t        e;
        logic [4:0]  last_rd   = 5'd0;
        logic [31:0] last_data = 32'd0;
        int          last_cnt  = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_i) begin
                chk("rst_fwd_valid", {31'd0, fwd_valid_o}, 32'd0);
                chk("rst_fwd_rd", {27'd0, fwd_rd_o}, 32'd0);
                chk("rst_fwd_data", fwd_data_o, 32'd0);
                chk("rst_cnt", {16'd0, commit_cnt_o}, 32'd0);
                chk("rst_cnt4", {28'd0, cnt4}, 32'd0);
                last_rd = 5'd0; last_data = 32'd0; last_cnt = 0;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fwd_valid", {31'd0, fwd_valid_o}, 32'd1);
                chk("fwd_rd", {27'd0, fwd_rd_o}, {27'd0, e.rd});
                chk("fwd_data", fwd_data_o, e.data);
                chk("commit_cnt", {16'd0, commit_cnt_o}, e.cnt % 65536);
                chk("commit_cnt4", {28'd0, cnt4}, e.cnt % 16);
                last_rd = e.rd; last_data = e.data; last_cnt = e.cnt;
            end else begin
                chk("idle_fwd_valid", {31'd0, fwd_valid_o}, 32'd0);
                chk("idle_fwd_rd", {27'd0, fwd_rd_o}, {27'd0, last_rd});
                chk("idle_fwd_data", fwd_data_o, last_data);
                chk("idle_cnt", {16'd0, commit_cnt_o}, last_cnt % 65536);
                chk("idle_cnt4", {28'd0, cnt4}, last_cnt % 16);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [4:0] rd, rs, rt;
        model_clear();
        // Reset held through clock edges: every address reads zero
        for (int a = 0; a < 32; a++) begin
            @(negedge clk_i);
            RSaddr_i = 5'(a); RTaddr_i = 5'(31 - a);
            #1;
            chk("rst_rs", RSdata_o, 32'd0);
            chk("rst_rt", RTdata_o, 32'd0);
        end
        @(negedge clk_i);
        rst_i = 1'b1;

        // Write/select
        drive(2'b10, 32'd0, 32'h1234_5678, 5'd5, 5'd0, 5'd0);
        drive(2'b11, 32'hDEAD_BEEF, 32'h0, 5'd6, 5'd5, 5'd0);
        drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd5, 5'd6);
        // Bypass: no-write cycle first shows old r9, then the write is visible before the edge
        drive(2'b01, 32'h5555_5555, 32'h7777_7777, 5'd9, 5'd9, 5'd9);
        drive(2'b10, 32'd0, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9);
        drive(2'b01, 32'h1, 32'h2, 5'd9, 5'd9, 5'd9);
        // Register 0 write is a complete no-op
        drive(2'b10, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9);
        // Forwarding record holds across an idle cycle
        drive(2'b10, 32'd0, 32'h11, 5'd3, 5'd3, 5'd0);
        drive(2'b00, 32'd0, 32'd0, 5'd3, 5'd3, 5'd0);
        drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        // 17 consecutive commits wrap the 4-bit counter through 0
        for (int i = 0; i < 17; i++) begin
            drive(2'b10, 32'd0, $urandom, 5'(i % 31 + 1), 5'(i % 31 + 1), 5'($urandom_range(0, 31)));
        end
        // Randomized traffic with biased register collisions
        for (int i = 0; i < 400; i++) begin
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            drive(2'($urandom_range(0, 3)), $urandom, $urandom, rd, rs, rt);
        end
        drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        // Mid-cycle reset with a write pending: outputs clear at once, bypass still shown, write discarded
        drive(2'b10, 32'd0, 32'h0BAD_F00D, 5'd12, 5'd12, 5'd0);
        @(negedge clk_i);
        WB_i = 2'b10; immed_i = 32'hCAFE_0007; mux3_i = 5'd7; RSaddr_i = 5'd7; RTaddr_i = 5'd12;
        #2;
        rst_i = 1'b0;
        model_clear();
        #1;
        chk("async_fwd_valid", {31'd0, fwd_valid_o}, 32'd0);
        chk("async_fwd_data", fwd_data_o, 32'd0);
        chk("async_cnt", {16'd0, commit_cnt_o}, 32'd0);
        chk("async_cnt4", {28'd0, cnt4}, 32'd0);
        chk("async_bypass", RSdata_o, 32'hCAFE_0007);
        chk("async_rt_zero", RTdata_o, 32'd0);
        @(negedge clk_i);
        WB_i = 2'b00;
        rst_i = 1'b1;
        #1;
        chk("discarded_write", RSdata_o, 32'd0);
        drive(2'b10, 32'd0, 32'h0000_0042, 5'd7, 5'd7, 5'd12);
        drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd7, 5'd12);
        drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
